// File: rtl/mc_arb_pkg.sv
// ---------------------------------------------------------------------------
// mc_pkg -- shared definitions for the mc_arb memory request arbiter.
//
// Contents:
//   mc_state_t      arbiter FSM state encoding (ST_IDLE, ST_ISSUE, ST_RESP)
//   DEF_NUM_PORTS   default number of requester ports
//   DEF_ADDR_W      default address width
//   DEF_DATA_W      default data width
//   clog2()         ceiling log2, never less than 1 so that index
//                   vectors always have at least one bit
// ---------------------------------------------------------------------------
package mc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } mc_state_t;

    localparam int DEF_NUM_PORTS = 3;
    localparam int DEF_ADDR_W    = 16;
    localparam int DEF_DATA_W    = 16;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result++;
        end
        if (result < 1) begin
            result = 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/mc_arb_if.sv
// ---------------------------------------------------------------------------
// mc_arb_if -- bundle of requester-side and backend-side signals of mc_arb.
//
// Requester side (NUM_PORTS ports, flattened vectors):
//   port_stb_i, port_we_i, port_addr_i, port_data_i   requests into arbiter
//   port_ack_o, port_err_o, port_data_o               responses from arbiter
// Backend side (single memory port):
//   mem_stb_o, mem_we_o, mem_addr_o, mem_data_o       request to memory
//   mem_ack_i, mem_data_i                             completion from memory
//
// Modports:
//   slave  -- the arbiter's view
//   master -- the environment's view (requesters plus memory backend)
// ---------------------------------------------------------------------------
interface mc_arb_if
    import mc_pkg::*;
#(
    parameter int NUM_PORTS = DEF_NUM_PORTS,
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int DATA_W    = DEF_DATA_W
);

    logic [NUM_PORTS-1:0]        port_stb_i;
    logic [NUM_PORTS-1:0]        port_we_i;
    logic [NUM_PORTS*ADDR_W-1:0] port_addr_i;
    logic [NUM_PORTS*DATA_W-1:0] port_data_i;
    logic [NUM_PORTS-1:0]        port_ack_o;
    logic [NUM_PORTS-1:0]        port_err_o;
    logic [DATA_W-1:0]           port_data_o;

    logic                        mem_stb_o;
    logic                        mem_we_o;
    logic [ADDR_W-1:0]           mem_addr_o;
    logic [DATA_W-1:0]           mem_data_o;
    logic                        mem_ack_i;
    logic [DATA_W-1:0]           mem_data_i;

    modport slave (
        input  port_stb_i, port_we_i, port_addr_i, port_data_i,
        output port_ack_o, port_err_o, port_data_o,
        output mem_stb_o, mem_we_o, mem_addr_o, mem_data_o,
        input  mem_ack_i, mem_data_i
    );

    modport master (
        output port_stb_i, port_we_i, port_addr_i, port_data_i,
        input  port_ack_o, port_err_o, port_data_o,
        input  mem_stb_o, mem_we_o, mem_addr_o, mem_data_o,
        output mem_ack_i, mem_data_i
    );

endinterface

// File: rtl/mc_arb_rr_arbiter.sv
// ---------------------------------------------------------------------------
// mc_rr_arbiter -- round-robin grant search with registered last-grant pointer.
//
// Ports:
//   clk     in   clock
//   rst_n   in   asynchronous active-low reset
//   req     in   NUM_PORTS request vector
//   update  in   commit the current grant as the new last-grant pointer
//   grant   out  index of the winning port (valid only with 'valid')
//   valid   out  at least one port is requesting
//
// The search starts one past the last granted port and wraps, so the port
// that just won has the lowest priority next time. After reset the pointer
// sits on the highest port, which makes port 0 the first winner.
// ---------------------------------------------------------------------------
module mc_rr_arbiter
    import mc_pkg::*;
#(
    parameter int NUM_PORTS = DEF_NUM_PORTS,
    localparam int IDX_W    = clog2(NUM_PORTS)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_PORTS-1:0] req,
    input  logic                 update,
    output logic [IDX_W-1:0]     grant,
    output logic                 valid
);

    logic [IDX_W-1:0] last_grant;

    // Walk the ports in priority order; the first requester found wins.
    always_comb begin
        int cand;
        grant = '0;
        valid = 1'b0;
        cand  = 0;
        for (int off = 1; off <= NUM_PORTS; off++) begin
            cand = int'(last_grant) + off;
            if (cand >= NUM_PORTS) begin
                cand = cand - NUM_PORTS;
            end
            if (!valid && req[cand[IDX_W-1:0]]) begin
                valid = 1'b1;
                grant = cand[IDX_W-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= IDX_W'(NUM_PORTS - 1);
        end else if (update) begin
            last_grant <= grant;
        end
    end

endmodule

// File: rtl/mc_arb.sv
// ---------------------------------------------------------------------------
// mc_arb -- N-port round-robin memory request arbiter, one transaction in
// flight, with per-port read-only protection.
//
// Ports:
//   sys_clk   in   clock, everything on the rising edge
//   sys_rst   in   asynchronous active-low reset
//   bus       mc_arb_if.slave: requester stb/we/addr/data in, ack/err/data
//             out; backend stb/we/addr/data out, ack/data in
//
// Optional build macro MC_ARB_TIMEOUT_EN: when defined, a request that the
// backend leaves unanswered for TIMEOUT cycles is completed with an error.
// Without it the arbiter waits for the backend indefinitely.
// ---------------------------------------------------------------------------
module mc_arb
    import mc_pkg::*;
#(
    parameter int                   NUM_PORTS = DEF_NUM_PORTS,
    parameter int                   ADDR_W    = DEF_ADDR_W,
    parameter int                   DATA_W    = DEF_DATA_W,
    parameter logic [NUM_PORTS-1:0] RO_MASK   = {{(NUM_PORTS-1){1'b0}}, 1'b1},
    parameter int                   TIMEOUT   = 255
) (
    input  logic   sys_clk,
    input  logic   sys_rst,
    mc_arb_if.slave bus
);

    localparam int IDX_W = clog2(NUM_PORTS);

    if (NUM_PORTS < 2 || NUM_PORTS > 8 || TIMEOUT < 1) begin : g_bad_cfg
        $error("mc_arb: NUM_PORTS must be 2..8 and TIMEOUT at least 1");
    end

    mc_state_t         state;
    mc_state_t         state_nxt;
    logic [IDX_W-1:0]  arb_grant;
    logic              arb_valid;
    logic              arb_update;
    logic [IDX_W-1:0]  grant_r;
    logic              we_r;
    logic              err_r;
    logic [ADDR_W-1:0] addr_r;
    logic [DATA_W-1:0] wdata_r;
    logic [DATA_W-1:0] rdata_r;
    logic              sel_we;
    logic              sel_reject;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_data;
    logic              timed_out;

    mc_rr_arbiter #(
        .NUM_PORTS (NUM_PORTS)
    ) u_rr (
        .clk    (sys_clk),
        .rst_n  (sys_rst),
        .req    (bus.port_stb_i),
        .update (arb_update),
        .grant  (arb_grant),
        .valid  (arb_valid)
    );

    assign sel_we     = bus.port_we_i[arb_grant];
    assign sel_addr   = bus.port_addr_i[int'(arb_grant)*ADDR_W +: ADDR_W];
    assign sel_data   = bus.port_data_i[int'(arb_grant)*DATA_W +: DATA_W];
    // A write from a read-only port never reaches the backend.
    assign sel_reject = sel_we && RO_MASK[arb_grant];

`ifdef MC_ARB_TIMEOUT_EN
    localparam int TO_W = (clog2(TIMEOUT + 1) > 8) ? clog2(TIMEOUT + 1) : 8;

    logic [TO_W-1:0] to_cnt;

    // Counts ISSUE cycles; sits at zero whenever no request is outstanding.
    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            to_cnt <= '0;
        end else if (state != ST_ISSUE) begin
            to_cnt <= '0;
        end else begin
            to_cnt <= to_cnt + TO_W'(1);
        end
    end

    // Fires in the last allowed ISSUE cycle; a same-cycle ack takes priority.
    assign timed_out = (state == ST_ISSUE) && (to_cnt == TO_W'(TIMEOUT - 1));
`else
    assign timed_out = 1'b0;
`endif

    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; the arbiter pointer advances only when a grant is taken.
    always_comb begin
        state_nxt  = state;
        arb_update = 1'b0;
        case (state)
            ST_IDLE: begin
                if (arb_valid) begin
                    arb_update = 1'b1;
                    state_nxt  = sel_reject ? ST_RESP : ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (bus.mem_ack_i || timed_out) begin
                    state_nxt = ST_RESP;
                end
            end
            ST_RESP: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Transaction registers: latched at grant, read data captured on backend ack.
    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            grant_r <= '0;
            we_r    <= 1'b0;
            err_r   <= 1'b0;
            addr_r  <= '0;
            wdata_r <= '0;
            rdata_r <= '0;
        end else if (state == ST_IDLE && arb_valid) begin
            grant_r <= arb_grant;
            we_r    <= sel_we;
            err_r   <= sel_reject;
            addr_r  <= sel_addr;
            wdata_r <= sel_data;
            rdata_r <= '0;
        end else if (state == ST_ISSUE) begin
            if (bus.mem_ack_i) begin
                if (!we_r) begin
                    rdata_r <= bus.mem_data_i;
                end
            end else if (timed_out) begin
                err_r <= 1'b1;
            end
        end
    end

    // Outputs are decoded from state so reset clears them immediately.
    always_comb begin
        bus.port_ack_o  = '0;
        bus.port_err_o  = '0;
        bus.port_data_o = '0;
        bus.mem_stb_o   = 1'b0;
        bus.mem_we_o    = 1'b0;
        bus.mem_addr_o  = '0;
        bus.mem_data_o  = '0;
        case (state)
            ST_ISSUE: begin
                bus.mem_stb_o  = 1'b1;
                bus.mem_we_o   = we_r;
                bus.mem_addr_o = addr_r;
                bus.mem_data_o = wdata_r;
            end
            ST_RESP: begin
                bus.port_ack_o[grant_r] = 1'b1;
                bus.port_err_o[grant_r] = err_r;
                bus.port_data_o         = rdata_r;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_mc_arb.sv
// ---------------------------------------------------------------------------
// tb_mc_arb -- self-checking bench for mc_arb (3 ports, port 0 read-only,
// TIMEOUT = 8). Expected responses are queued when a request is driven and
// consumed by a monitor whenever the arbiter acks a port. A small backend
// model answers mem_stb_o after a programmable number of wait cycles.
// Build with MC_ARB_TIMEOUT_EN defined to exercise the timeout path.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_mc_arb;
    import mc_pkg::*;

    localparam int NP = 3;
    localparam int AW = 16;
    localparam int DW = 16;

    typedef struct {
        int          port;
        logic [15:0] data;
        logic        err;
    } exp_t;

    logic clk;
    logic rst_n;

    exp_t sb[$];
    int   n_cmp       = 0;
    int   n_err       = 0;
    int   stb_cycles  = 0;

    // Backend model controls, written only by the main sequence.
    bit          be_enable    = 0;
    bit          be_force_ack = 0;
    bit          be_xor       = 0;
    int          be_wait      = 0;
    logic [15:0] be_data      = '0;

    mc_arb_if #(.NUM_PORTS(NP), .ADDR_W(AW), .DATA_W(DW)) bus ();

    mc_arb #(
        .NUM_PORTS (NP),
        .ADDR_W    (AW),
        .DATA_W    (DW),
        .RO_MASK   (3'b001),
        .TIMEOUT   (8)
    ) dut (
        .sys_clk (clk),
        .sys_rst (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input int port, input logic stb, input logic we,
                                 input logic [15:0] addr, input logic [15:0] data);
        bus.port_stb_i[port]            = stb;
        bus.port_we_i[port]             = we;
        bus.port_addr_i[port*AW +: AW]  = addr;
        bus.port_data_i[port*DW +: DW]  = data;
    endtask

    task automatic pushExp(input int port, input logic [15:0] data, input logic err);
        exp_t e;
        e.port = port;
        e.data = data;
        e.err  = err;
        sb.push_back(e);
    endtask

    // Waits (bounded) for an ack on 'port'; exp_off is the number of negedges
    // expected to pass before the ack shows up (0 = the very next negedge).
    task automatic waitAck(input int port, input int exp_off, input string tag);
        int  off;
        bit  seen;
        off  = 0;
        seen = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus.port_ack_o[port]) begin
                off  = i;
                seen = 1;
                break;
            end
        end
        checkOutput({tag, "_ack_seen"}, 32'(seen), 32'd1);
        if (seen) checkOutput({tag, "_latency"}, 32'(off), 32'(exp_off));
    endtask

    // Backend model: acks after be_wait further cycles of mem_stb_o.
    initial begin
        int cnt;
        cnt           = 0;
        bus.mem_ack_i = 1'b0;
        bus.mem_data_i = '0;
        forever begin
            @(posedge clk);
            #1;
            bus.mem_ack_i  = 1'b0;
            bus.mem_data_i = '0;
            if (be_force_ack) begin
                bus.mem_ack_i = 1'b1;
            end else if (be_enable && bus.mem_stb_o) begin
                if (cnt >= be_wait) begin
                    bus.mem_ack_i  = 1'b1;
                    bus.mem_data_i = be_xor ? (bus.mem_addr_o ^ 16'h5555) : be_data;
                    cnt = 0;
                end else begin
                    cnt++;
                end
            end else begin
                cnt = 0;
            end
        end
    end

    // Response monitor: every ack/err pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (bus.mem_stb_o) stb_cycles++;
        if (bus.port_ack_o != '0 || bus.port_err_o != '0) begin
            if (sb.size() == 0) begin
                checkOutput("unexpected_ack", 32'(bus.port_ack_o), 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                checkOutput("ack_vec",  32'(bus.port_ack_o),  32'(3'b001 << e.port));
                checkOutput("err_vec",  32'(bus.port_err_o),  e.err ? 32'(3'b001 << e.port) : 32'd0);
                checkOutput("rd_data",  32'(bus.port_data_o), 32'(e.data));
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int acks;
        int hi;
        int stb_before;
        bit acked;

        bus.port_stb_i  = '0;
        bus.port_we_i   = '0;
        bus.port_addr_i = '0;
        bus.port_data_i = '0;
        rst_n = 1'b0;

        // Reset state.
        repeat (2) @(negedge clk);
        checkOutput("rst_mem_stb",  32'(bus.mem_stb_o),  32'd0);
        checkOutput("rst_port_ack", 32'(bus.port_ack_o), 32'd0);
        checkOutput("rst_mem_addr", 32'(bus.mem_addr_o), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("idle_mem_stb", 32'(bus.mem_stb_o), 32'd0);

        // Read on port 1, backend answers two cycles after the request.
        $display("[TB] read port 1");
        be_enable = 1; be_wait = 1; be_data = 16'hBEEF; be_xor = 0;
        @(posedge clk); #1;
        pushExp(1, 16'hBEEF, 1'b0);
        applyStimulus(1, 1'b1, 1'b0, 16'h0040, 16'h0000);
        @(negedge clk);
        @(negedge clk);
        checkOutput("rd_mem_stb_c1",  32'(bus.mem_stb_o),  32'd1);
        checkOutput("rd_mem_we",      32'(bus.mem_we_o),   32'd0);
        checkOutput("rd_mem_addr_c1", 32'(bus.mem_addr_o), 32'h0040);
        @(negedge clk);
        checkOutput("rd_mem_stb_c2",  32'(bus.mem_stb_o),  32'd1);
        checkOutput("rd_mem_addr_c2", 32'(bus.mem_addr_o), 32'h0040);
        waitAck(1, 0, "rd_p1");
        @(posedge clk); #1;
        applyStimulus(1, 1'b0, 1'b0, 16'h0000, 16'h0000);

        // Write on port 2 with a zero-wait backend.
        $display("[TB] write port 2");
        be_wait = 0;
        @(posedge clk); #1;
        pushExp(2, 16'h0000, 1'b0);
        applyStimulus(2, 1'b1, 1'b1, 16'h1234, 16'h5A5A);
        @(negedge clk);
        @(negedge clk);
        checkOutput("wr_mem_stb",  32'(bus.mem_stb_o),  32'd1);
        checkOutput("wr_mem_we",   32'(bus.mem_we_o),   32'd1);
        checkOutput("wr_mem_addr", 32'(bus.mem_addr_o), 32'h1234);
        checkOutput("wr_mem_data", 32'(bus.mem_data_o), 32'h5A5A);
        waitAck(2, 0, "wr_p2");
        @(posedge clk); #1;
        applyStimulus(2, 1'b0, 1'b0, 16'h0000, 16'h0000);

        // All ports requesting continuously: pointer is on port 2, so 0,1,2,0,1,2.
        $display("[TB] fairness");
        be_xor = 1;
        @(posedge clk); #1;
        for (int r = 0; r < 2; r++) begin
            for (int p = 0; p < NP; p++) begin
                pushExp(p, 16'(16'h0100 * (p + 1)) ^ 16'h5555, 1'b0);
            end
        end
        for (int p = 0; p < NP; p++) begin
            applyStimulus(p, 1'b1, 1'b0, 16'(16'h0100 * (p + 1)), 16'h0000);
        end
        acks = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (bus.port_ack_o != '0) acks++;
            if (acks == 6) break;
        end
        @(posedge clk); #1;
        for (int p = 0; p < NP; p++) begin
            applyStimulus(p, 1'b0, 1'b0, 16'h0000, 16'h0000);
        end
        checkOutput("fair_ack_count", 32'(acks), 32'd6);
        checkOutput("fair_sb_drained", 32'(sb.size()), 32'd0);

        // Write on read-only port 0: rejected without touching the backend.
        $display("[TB] read-only write port 0");
        be_xor = 0;
        @(posedge clk); #1;
        stb_before = stb_cycles;
        pushExp(0, 16'h0000, 1'b1);
        applyStimulus(0, 1'b1, 1'b1, 16'h0010, 16'h1234);
        waitAck(0, 1, "ro_p0");
        @(posedge clk); #1;
        applyStimulus(0, 1'b0, 1'b0, 16'h0000, 16'h0000);
        @(negedge clk);
        #1;
        checkOutput("ro_no_mem_stb", 32'(stb_cycles - stb_before), 32'd0);

        // Unanswered backend request on port 1.
        $display("[TB] silent backend");
        be_enable = 0;
        @(posedge clk); #1;
`ifdef MC_ARB_TIMEOUT_EN
        pushExp(1, 16'h0000, 1'b1);
`endif
        applyStimulus(1, 1'b1, 1'b0, 16'h0200, 16'h0000);
        @(negedge clk);
        hi    = 0;
        acked = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.port_ack_o[1]) begin
                acked = 1;
                break;
            end
            if (bus.mem_stb_o) hi++;
        end
`ifdef MC_ARB_TIMEOUT_EN
        checkOutput("to_acked",    32'(acked), 32'd1);
        checkOutput("to_stb_high", 32'(hi),    32'd8);
        // The held stb is taken as a fresh request: IDLE, then ISSUE again.
        @(negedge clk);
        @(negedge clk);
`else
        checkOutput("noto_acked",    32'(acked), 32'd0);
        checkOutput("noto_stb_high", 32'(hi),    32'd20);
`endif

        // Reset while in ISSUE clears every output at once.
        $display("[TB] reset during issue");
        checkOutput("pre_rst_stb", 32'(bus.mem_stb_o), 32'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("mid_rst_mem_stb",  32'(bus.mem_stb_o),   32'd0);
        checkOutput("mid_rst_mem_we",   32'(bus.mem_we_o),    32'd0);
        checkOutput("mid_rst_mem_addr", 32'(bus.mem_addr_o),  32'd0);
        checkOutput("mid_rst_mem_data", 32'(bus.mem_data_o),  32'd0);
        checkOutput("mid_rst_ack_err",  32'({bus.port_ack_o, bus.port_err_o}), 32'd0);
        checkOutput("mid_rst_pdata",    32'(bus.port_data_o), 32'd0);
        @(negedge clk);
        be_force_ack = 1;
        @(negedge clk);
        // A stale backend ack is present on the first edge after release.
        be_force_ack = 0;
        be_data      = 16'h1111;
        pushExp(1, 16'h1111, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("post_rst_issue",  32'(bus.mem_stb_o),  32'd1);
        checkOutput("post_rst_no_ack", 32'(bus.port_ack_o), 32'd0);
        checkOutput("post_rst_addr",   32'(bus.mem_addr_o), 32'h0200);
        be_enable = 1;
        be_wait   = 0;
        waitAck(1, 1, "post_rst");
        @(posedge clk); #1;
        applyStimulus(1, 1'b0, 1'b0, 16'h0000, 16'h0000);
        repeat (3) @(negedge clk);

        checkOutput("sb_drained", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
